// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg
//   Shared encodings and default sizes for the tick generator and its
//   button debouncer.
package tick_gen_pkg;

    // Debounce FSM encodings.
    typedef enum logic [1:0] {
        REL     = 2'd0,
        WAIT_P  = 2'd1,
        PRESSED = 2'd2,
        WAIT_R  = 2'd3
    } db_state_t;

    // Default prescale width.
    localparam int TG_DIV_W = 6;

    // Board build: about 10 ms of stable level at 50 MHz.
    localparam int TG_DEBOUNCE_BOARD = 500000;

    // Default debounce counter width; holds TG_DEBOUNCE_BOARD-1.
    localparam int TG_DB_W = 20;

endpackage

// File: rtl/tick_gen_go_debounce.sv
// go_debounce
//   Takes the raw active-low step button into the clk domain and debounces
//   it. The output is one strobe per accepted press plus a level for the LED.
//
//   Ports:
//     i_clk       system clock
//     i_rst       asynchronous active-high reset
//     i_go_n      raw button, active-low, asynchronous to i_clk
//     o_go_pulse  registered one-cycle strobe on an accepted press
//     o_go_level  debounced pressed level
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   REL     | button released and stable
//   WAIT_P  | low seen, counting stable low samples before accepting
//   PRESSED | press accepted
//   WAIT_R  | high seen, counting stable high samples before releasing
module go_debounce
    import tick_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = TG_DB_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_go_n,
    output logic o_go_pulse,
    output logic o_go_level
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    db_state_t       r_state;
    db_state_t       w_state_nxt;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nxt;
    logic            r_go_pulse;
    logic            w_go_pulse_nxt;

    // Synchronizer flops reset to 1 so a released button looks idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_go_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= REL;
            r_db_cnt   <= '0;
            r_go_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
            r_go_pulse <= w_go_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_db_cnt_nxt   = r_db_cnt;
        w_go_pulse_nxt = 1'b0;
        case (r_state)
            REL: begin
                if (!r_sync2) begin
                    w_state_nxt  = WAIT_P;
                    w_db_cnt_nxt = '0;
                end
            end
            WAIT_P: begin
                if (r_sync2) begin
                    w_state_nxt = REL;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt    = PRESSED;
                    w_go_pulse_nxt = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (r_sync2) begin
                    w_state_nxt  = WAIT_R;
                    w_db_cnt_nxt = '0;
                end
            end
            WAIT_R: begin
                // Bouncing back low returns to PRESSED without a new strobe.
                if (!r_sync2) begin
                    w_state_nxt = PRESSED;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt = REL;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = REL;
            end
        endcase
    end

    assign o_go_pulse = r_go_pulse;
    assign o_go_level = (r_state == PRESSED) || (r_state == WAIT_R);

endmodule

// File: rtl/tick_gen.sv
// tick_gen
//   Produces the count-enable strobe for the board up/down counter: either a
//   prescaled periodic tick or one tick per debounced step-button press.
//
//   Ports:
//     clk       system clock (MAX10_CLK1_50)
//     reset     asynchronous active-high reset
//     enable    global enable; 0 suppresses all ticks
//     free_run  1 = periodic ticks, 0 = single-step on button press
//     divideby  prescale terminal value; period = divideby+1 clocks
//     go_n      raw step button, active-low
//     tick      registered single-cycle count strobe
//     go_pulse  registered single-cycle strobe on an accepted press
//     go_level  debounced pressed level
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int DIV_W           = TG_DIV_W,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DB_W            = TG_DB_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             free_run,
    input  logic [DIV_W-1:0] divideby,
    input  logic             go_n,
    output logic             tick,
    output logic             go_pulse,
    output logic             go_level
);

    logic [DIV_W-1:0] r_pre_cnt;
    logic             r_tick;
    logic             w_go_pulse;
    logic             w_go_level;

    go_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_go_debounce (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_go_n     (go_n),
        .o_go_pulse (w_go_pulse),
        .o_go_level (w_go_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (!enable) begin
            // Counter holds so re-enabling resumes the same phase.
            r_tick <= 1'b0;
        end else if (free_run) begin
            // >= rather than == so lowering divideby below the current count
            // ticks at once instead of wrapping through the full range.
            if (r_pre_cnt >= divideby) begin
                r_tick    <= 1'b1;
                r_pre_cnt <= '0;
            end else begin
                r_tick    <= 1'b0;
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
        end else begin
            r_tick    <= w_go_pulse;
            r_pre_cnt <= '0;
        end
    end

    assign tick     = r_tick;
    assign go_pulse = w_go_pulse;
    assign go_level = w_go_level;

endmodule
